alu_share_arb: RTL

//  Shares the single 16-bit ALU between two requesters (0: pipeline EX stage, 1: auxiliary/microcode unit).

---
 rtl/alu_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/alu_share_arb.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing block.
// Contents: ALU opcode encodings, {Z,V,N} flag bit indices and the
// arbiter/sequencer FSM state type. Imported with import alu_pkg::*.
package alu_pkg;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_RED    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADDSB = 3'b111;

  // Bit positions inside a {Z,V,N} flag vector.
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req[1:0]    request lines (bit N = requester N)
//   advance     a grant is being consumed this cycle; priority rotates
//   gnt[1:0]    one-hot grant (combinational from req and the priority flop)
// Parameter PRIO_RST selects which requester wins a tie after reset.
module rr_arb2 #(
  parameter bit PRIO_RST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic prio_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio_q ? 2'b10 : 2'b01;
  end

  // After serving requester N the other one holds priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= PRIO_RST;
    end else if (advance && (gnt != 2'b00)) begin
      prio_q <= gnt[0];
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one 16-bit ALU between requester 0 (pipeline EX stage) and
// requester 1 (auxiliary/microcode unit). One operation in flight.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready/opcode/a/b  request channel N (N = 0, 1)
//   rspN_valid/ready           response channel N
//   rsp_data, rsp_flags        registered result and per-op {Z,V,N}
//   flags_q                    architectural {Z,V,N} register
//   alu_in1/in2/opcode/isalu   drive the external ALU
//   alu_out/flags/flags_set    results from the external ALU
//   dbg_state                  current FSM state
// Macro ALU_SHARE_FLAGS_EN: when defined, flags_q is a register loaded in
// EXEC from alu_flags whenever alu_flags_set is high; otherwise it is 000.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold valid and operands stable until ready and never
// retract; ready is only offered in IDLE to the granted requester. Responses
// hold rsp_data/rsp_flags stable until the owner's rspN_ready.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int DW       = 16,
  parameter bit PRIO_RST = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [2:0]    req0_opcode,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [2:0]    req1_opcode,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp_data,
  output logic [2:0]    rsp_flags,
  output logic [2:0]    flags_q,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [2:0]    alu_opcode,
  output logic          alu_isalu,
  input  logic [DW-1:0] alu_out,
  input  logic [2:0]    alu_flags,
  input  logic          alu_flags_set,
  output state_t        dbg_state
);

  state_t        state_q;
  logic          owner_q;
  logic [2:0]    op_q;
  logic [DW-1:0] a_q, b_q, data_q;
  logic [2:0]    rflags_q;
  logic          isalu_q, rsp0_q, rsp1_q;
  logic [1:0]    arb_req, gnt;
  logic          idle, rsp_done;

  // Requests are only visible to the arbiter in IDLE, so gnt is zero elsewhere.
  assign idle    = (state_q == IDLE);
  assign arb_req = {req1_valid, req0_valid} & {2{idle}};

  rr_arb2 #(.PRIO_RST(PRIO_RST)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (idle),
    .gnt     (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign rsp_done   = (rsp0_q & rsp0_ready) | (rsp1_q & rsp1_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      op_q     <= 3'b000;
      a_q      <= '0;
      b_q      <= '0;
      data_q   <= '0;
      rflags_q <= 3'b000;
      isalu_q  <= 1'b0;
      rsp0_q   <= 1'b0;
      rsp1_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt != 2'b00) begin
            owner_q <= gnt[1];
            op_q    <= gnt[1] ? req1_opcode : req0_opcode;
            a_q     <= gnt[1] ? req1_a : req0_a;
            b_q     <= gnt[1] ? req1_b : req0_b;
            isalu_q <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          data_q   <= alu_out;
          rflags_q <= alu_flags_set ? alu_flags : 3'b000;
          isalu_q  <= 1'b0;
          rsp0_q   <= ~owner_q;
          rsp1_q   <= owner_q;
          state_q  <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            rsp0_q  <= 1'b0;
            rsp1_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_SHARE_FLAGS_EN
  logic [2:0] flags_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg <= 3'b000;
    end else if ((state_q == EXEC) && alu_flags_set) begin
      flags_reg <= alu_flags;
    end
  end
  assign flags_q = flags_reg;
`else
  assign flags_q = 3'b000;
`endif

  assign alu_in1    = a_q;
  assign alu_in2    = b_q;
  assign alu_opcode = op_q;
  assign alu_isalu  = isalu_q;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign rsp_data   = data_q;
  assign rsp_flags  = rflags_q;
  assign dbg_state  = state_q;

endmodule
